fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the MSP430 core. It replaces the single-word fetch in the core pipeline with a PC-driven prefetcher. The prefetcher issues word reads over a req/ack memory port and buffers returned words in a DEPTH-entry queue. It hands them to decode through a valid/ready handshake, and handles PC redirects (jumps, calls, interrupts) by flushing the queue and discarding any in-flight read.

---
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetcher: issues PC-driven word reads over a req/ack port and
// buffers returned words in a DEPTH-entry queue for decode; redirects flush it.
module fetch_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RST_VEC,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             ir_valid,
  output logic [WIDTH-1:0] ir_word,
  output logic [WIDTH-1:0] ir_pc,
  input  logic             ir_ready,
  output logic [WIDTH-1:0] fetch_pc,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];

  logic             push, pop, flush;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] pc_inc, redir_pc;

  assign ir_valid = (count_q != '0);
  assign pop      = ir_valid & ir_ready;
  assign cnt_nx   = count_q - CW'(pop);
  assign pc_inc   = fetch_pc_q + WIDTH'(2);
  assign redir_pc = {redirect_pc[WIDTH-1:1], 1'b0};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redir_pc;
        end else if (cnt_nx < DEPTH_C) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redir_pc;
          state_d    = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_inc;
          // Keep the request asserted only if a slot stays reserved for it.
          if ((cnt_nx + CW'(1)) < DEPTH_C) begin
            addr_d = pc_inc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redir_pc;
        end
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= {RST_VEC[WIDTH-1:1], 1'b0};
      addr_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage carries no reset; entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= addr_q;
    end
  end

  assign mem_req  = (state_q == WAIT) || (state_q == DISCARD);
  assign mem_addr = addr_q;
  assign ir_word  = word_q[rd_ptr_q];
  assign ir_pc    = pc_q[rd_ptr_q];
  assign fetch_pc = fetch_pc_q;
  assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/pop, redirects, PC wrap and streaming.
module tb_fetch_queue;

  logic        clk, rst;
  logic [15:0] RST_VEC;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_valid, ir_ready;
  logic [15:0] ir_word, ir_pc, fetch_pc;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  fetch_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .RST_VEC(RST_VEC),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_word(ir_word), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .fetch_pc(fetch_pc), .count(count)
  );

  // Memory model: each word's data is its address scrambled by a fixed mask.
  assign mem_rdata = mem_addr ^ 16'h5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] vec);
    rst = 1'b1; RST_VEC = vec; redirect = 1'b0; redirect_pc = 16'h0;
    mem_ack = 1'b0; ir_ready = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    do_reset(16'hC000);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", ir_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (fetch_pc !== 16'hC000) begin failures++; $display("FAIL reset_fetch_pc got %h want c000", fetch_pc); end
    rst = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL first_req got %b want 1", mem_req); end
    checks++; if (mem_addr !== 16'hC000) begin failures++; $display("FAIL first_addr got %h want c000", mem_addr); end
  endtask

  task automatic test_fill_and_pop();
    do_reset(16'hC000);
    rst = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hC000 + 16'(2*i)) begin
        failures++; $display("FAIL fill_read%0d got req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, 16'hC000 + 16'(2*i)); end
    end
    step();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_req got %b want 0", mem_req); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got %0d want 4", count); end
    checks++; if (ir_pc !== 16'hC000 || ir_word !== (16'hC000 ^ 16'h5A5A)) begin
      failures++; $display("FAIL full_head got pc=%h word=%h want pc=c000 word=%h", ir_pc, ir_word, 16'hC000 ^ 16'h5A5A); end
    step();
    checks++; if (mem_req !== 1'b0 || count !== 3'd4) begin failures++; $display("FAIL full_hold got req=%b count=%0d want 0/4", mem_req, count); end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL pop_count got %0d want 3", count); end
    checks++; if (ir_pc !== 16'hC002) begin failures++; $display("FAIL pop_head got %h want c002", ir_pc); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hC008) begin
      failures++; $display("FAIL refill_req got req=%b addr=%h want 1/c008", mem_req, mem_addr); end
    step();
    checks++; if (count !== 3'd4 || mem_req !== 1'b0) begin
      failures++; $display("FAIL refill_full got count=%0d req=%b want 4/0", count, mem_req); end
    checks++; if (fetch_pc !== 16'hC00A) begin failures++; $display("FAIL refill_fetch_pc got %h want c00a", fetch_pc); end
  endtask

  task automatic test_redirect_outstanding();
    do_reset(16'hC000);
    rst = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL redir_pre_count got %0d want 1", count); end
    mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'hD001;
    step();
    redirect = 1'b0;
    checks++; if (count !== 3'd0 || ir_valid !== 1'b0) begin
      failures++; $display("FAIL redir_flush got count=%0d valid=%b want 0/0", count, ir_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hC002) begin
      failures++; $display("FAIL redir_hold got req=%b addr=%h want 1/c002", mem_req, mem_addr); end
    checks++; if (fetch_pc !== 16'hD000) begin failures++; $display("FAIL redir_fetch_pc got %h want d000", fetch_pc); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hC002) begin
      failures++; $display("FAIL redir_wait got req=%b addr=%h want 1/c002", mem_req, mem_addr); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL discard_drop got count=%0d req=%b want 0/0", count, mem_req); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hD000) begin
      failures++; $display("FAIL redir_target got req=%b addr=%h want 1/d000", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset(16'hC000);
    rst = 1'b0; mem_ack = 1'b1;
    step(); step(); step();
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL rap_pre_count got %0d want 2", count); end
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hE000;
    step();
    redirect = 1'b0; ir_ready = 1'b0; mem_ack = 1'b0;
    checks++; if (count !== 3'd0 || ir_valid !== 1'b0) begin
      failures++; $display("FAIL rap_count got count=%0d valid=%b want 0/0", count, ir_valid); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rap_idle got req=%b want 0", mem_req); end
    checks++; if (fetch_pc !== 16'hE000) begin failures++; $display("FAIL rap_fetch_pc got %h want e000", fetch_pc); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hE000) begin
      failures++; $display("FAIL rap_target got req=%b addr=%h want 1/e000", mem_req, mem_addr); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd1 || ir_pc !== 16'hE000 || ir_word !== (16'hE000 ^ 16'h5A5A)) begin
      failures++; $display("FAIL rap_push got count=%0d pc=%h word=%h want 1/e000/%h", count, ir_pc, ir_word, 16'hE000 ^ 16'h5A5A); end
  endtask

  task automatic test_pc_wrap();
    do_reset(16'hFFFE);
    checks++; if (fetch_pc !== 16'hFFFE) begin failures++; $display("FAIL wrap_reset got %h want fffe", fetch_pc); end
    rst = 1'b0; mem_ack = 1'b1;
    step();
    checks++; if (mem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_addr0 got %h want fffe", mem_addr); end
    step();
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr1 got %h want 0000", mem_addr); end
    checks++; if (ir_pc !== 16'hFFFE || ir_word !== (16'hFFFE ^ 16'h5A5A)) begin
      failures++; $display("FAIL wrap_head0 got pc=%h word=%h want fffe/%h", ir_pc, ir_word, 16'hFFFE ^ 16'h5A5A); end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0; mem_ack = 1'b0;
    checks++; if (count !== 3'd1 || ir_pc !== 16'h0000 || ir_word !== 16'h5A5A) begin
      failures++; $display("FAIL wrap_head1 got count=%0d pc=%h word=%h want 1/0000/5a5a", count, ir_pc, ir_word); end
    checks++; if (fetch_pc !== 16'h0002) begin failures++; $display("FAIL wrap_fetch_pc got %h want 0002", fetch_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset(16'hC000);
    rst = 1'b0; mem_ack = 1'b1;
    step(); step(); step();
    checks++; if (count !== 3'd2 || mem_req !== 1'b1) begin
      failures++; $display("FAIL mid_pre got count=%0d req=%b want 2/1", count, mem_req); end
    rst = 1'b1;
    step();
    checks++; if (count !== 3'd0 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset got count=%0d req=%b valid=%b want 0/0/0", count, mem_req, ir_valid); end
    checks++; if (fetch_pc !== 16'hC000 || mem_addr !== 16'h0) begin
      failures++; $display("FAIL mid_reset_pc got fetch_pc=%h addr=%h want c000/0000", fetch_pc, mem_addr); end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(16'hC000);
    rst = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1;
    step(); step();
    checks++; if (count !== 3'd1 || ir_pc !== 16'hC000) begin
      failures++; $display("FAIL b2b_first got count=%0d pc=%h want 1/c000", count, ir_pc); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (count !== 3'd1 || ir_pc !== 16'hC002 + 16'(2*k) || ir_word !== ((16'hC002 + 16'(2*k)) ^ 16'h5A5A)) begin
        failures++; $display("FAIL b2b_word%0d got count=%0d pc=%h word=%h want 1/%h", k, count, ir_pc, ir_word, 16'hC002 + 16'(2*k)); end
    end
    mem_ack = 1'b0; ir_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; RST_VEC = 16'hC000; mem_ack = 1'b0; redirect = 1'b0;
    redirect_pc = 16'h0; ir_ready = 1'b0;
    test_reset();
    test_fill_and_pop();
    test_redirect_outstanding();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
